// File: rtl/enc_lookup_ctrl.sv
// enc_lookup_ctrl: per-batch controller for the encoder lookup table (allocate, record, send, check, read back, free).
// Optional CHECK-state watchdog is built when ENC_LOOKUP_CTRL_TIMEOUT_EN is defined.
module enc_lookup_ctrl #(
    parameter int unsigned TABLE_ROW      = 32,
    parameter int unsigned TABLE_COL      = 128,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_BANK       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_last,
    input  logic [NUM_BANK*DATA_WIDTH-1:0] req_data,
    output logic [1:0]                     record_en,
    output logic                           sent_en,
    output logic                           check_en,
    output logic                           invalid_en,
    output logic                           feat_rd_en,
    output logic [DATA_WIDTH-1:0]          target_row_id,
    output logic [DATA_WIDTH-1:0]          target_col_id,
    output logic [NUM_BANK*DATA_WIDTH-1:0] hash_indices,
    output logic [TABLE_COL-1:0]           sent_in,
    input  logic                           full,
    input  logic                           allocated,
    input  logic                           all_returned,
    input  logic [DATA_WIDTH-1:0]          alloc_row_id,
    input  logic [NUM_BANK*DATA_WIDTH-1:0] feat_rd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_BANK*DATA_WIDTH-1:0] out_data,
    output logic                           out_last,
    output logic                           busy
);

    localparam int unsigned BUS_W = NUM_BANK * DATA_WIDTH;
    localparam int unsigned BEATS = TABLE_COL / NUM_BANK;
    localparam int unsigned COL_W = $clog2(BEATS + 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(BEATS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ALLOC  = 3'd1;
    localparam logic [2:0] S_AWAIT  = 3'd2;
    localparam logic [2:0] S_RECORD = 3'd3;
    localparam logic [2:0] S_SEND   = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_READ   = 3'd6;
    localparam logic [2:0] S_FREE   = 3'd7;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [COL_W-1:0]      rd_col_q, rd_col_d;
    logic [TABLE_COL-1:0]  mask_q, mask_d;
    logic                  overflow_q, overflow_d;

    logic [1:0]            record_en_q, record_en_d;
    logic                  sent_en_q, sent_en_d;
    logic                  check_en_q, check_en_d;
    logic                  invalid_en_q, invalid_en_d;
    logic                  feat_rd_en_q, feat_rd_en_d;
    logic                  rd_last_q, rd_last_d;
    logic [DATA_WIDTH-1:0] target_row_id_q, target_row_id_d;
    logic [DATA_WIDTH-1:0] target_col_id_q, target_col_id_d;
    logic [BUS_W-1:0]      hash_indices_q, hash_indices_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;

    logic                  req_ready_c;
    logic                  beat_take;
    logic                  last_beat;
    logic                  row_ok;

`ifdef ENC_LOOKUP_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_err_q, timeout_err_d;
    logic            timeout_seen_q, timeout_seen_d;
`endif

    // A grant naming a row outside the table is treated as a refusal and retried.
    assign row_ok    = (alloc_row_id < DATA_WIDTH'(TABLE_ROW));
    assign last_beat = req_last || (col_q == LAST_COL);

    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        col_d           = col_q;
        rd_col_d        = rd_col_q;
        mask_d          = mask_q;
        overflow_d      = overflow_q;
        record_en_d     = 2'b00;
        sent_en_d       = 1'b0;
        check_en_d      = 1'b0;
        invalid_en_d    = 1'b0;
        feat_rd_en_d    = 1'b0;
        rd_last_d       = 1'b0;
        target_row_id_d = '0;
        target_col_id_d = '0;
        hash_indices_d  = hash_indices_q;
        req_ready_c     = 1'b0;
        beat_take       = 1'b0;
`ifdef ENC_LOOKUP_CTRL_TIMEOUT_EN
        to_cnt_d        = to_cnt_q;
        timeout_err_d   = 1'b0;
        timeout_seen_d  = timeout_seen_q | timeout_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid) state_d = S_ALLOC;
            end
            S_ALLOC: begin
                if (!full) begin
                    record_en_d    = 2'b01;
                    hash_indices_d = req_data;
                    state_d        = S_AWAIT;
                end
            end
            S_AWAIT: begin
                if (allocated && row_ok) begin
                    req_ready_c = 1'b1;
                    row_d       = alloc_row_id;
                    beat_take   = 1'b1;
                end else begin
                    state_d = S_ALLOC;
                end
            end
            S_RECORD: begin
                req_ready_c = 1'b1;
                if (req_valid) begin
                    record_en_d     = 2'b11;
                    target_row_id_d = row_q;
                    target_col_id_d = DATA_WIDTH'(col_q);
                    hash_indices_d  = req_data;
                    beat_take       = 1'b1;
                end
            end
            S_SEND: begin
                sent_en_d       = 1'b1;
                target_row_id_d = row_q;
                state_d         = S_CHECK;
            end
            S_CHECK: begin
                check_en_d      = 1'b1;
                target_row_id_d = row_q;
                if (all_returned) begin
                    state_d = S_READ;
`ifdef ENC_LOOKUP_CTRL_TIMEOUT_EN
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d       = S_FREE;
                    timeout_err_d = 1'b1;
                    to_cnt_d      = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            S_READ: begin
                if ((rd_col_q != col_q) && out_ready) begin
                    feat_rd_en_d    = 1'b1;
                    target_row_id_d = row_q;
                    target_col_id_d = DATA_WIDTH'(rd_col_q);
                    rd_last_d       = (rd_col_q == col_q - 1'b1);
                    rd_col_d        = rd_col_q + 1'b1;
                end
                if (out_valid_q && out_last_q) state_d = S_FREE;
            end
            S_FREE: begin
                invalid_en_d    = 1'b1;
                target_row_id_d = row_q;
                row_d           = '0;
                col_d           = '0;
                rd_col_d        = '0;
                mask_d          = '0;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Shared bookkeeping for beat 0 (AWAIT) and later beats (RECORD).
        if (beat_take) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
                if (COL_W'(b) == col_q) mask_d[b*NUM_BANK +: NUM_BANK] = '1;
            end
            col_d = col_q + 1'b1;
            if ((col_q == LAST_COL) && !req_last) overflow_d = 1'b1;
            state_d = last_beat ? S_SEND : S_RECORD;
        end
    end

    // The read pipe mirrors the table's one-cycle read latency.
    assign out_valid_d = feat_rd_en_q;
    assign out_last_d  = rd_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            row_q           <= '0;
            col_q           <= '0;
            rd_col_q        <= '0;
            mask_q          <= '0;
            overflow_q      <= 1'b0;
            record_en_q     <= 2'b00;
            sent_en_q       <= 1'b0;
            check_en_q      <= 1'b0;
            invalid_en_q    <= 1'b0;
            feat_rd_en_q    <= 1'b0;
            rd_last_q       <= 1'b0;
            target_row_id_q <= '0;
            target_col_id_q <= '0;
            hash_indices_q  <= '0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            col_q           <= col_d;
            rd_col_q        <= rd_col_d;
            mask_q          <= mask_d;
            overflow_q      <= overflow_d;
            record_en_q     <= record_en_d;
            sent_en_q       <= sent_en_d;
            check_en_q      <= check_en_d;
            invalid_en_q    <= invalid_en_d;
            feat_rd_en_q    <= feat_rd_en_d;
            rd_last_q       <= rd_last_d;
            target_row_id_q <= target_row_id_d;
            target_col_id_q <= target_col_id_d;
            hash_indices_q  <= hash_indices_d;
            out_valid_q     <= out_valid_d;
            out_last_q      <= out_last_d;
        end
    end

`ifdef ENC_LOOKUP_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q       <= '0;
            timeout_err_q  <= 1'b0;
            timeout_seen_q <= 1'b0;
        end else begin
            to_cnt_q       <= to_cnt_d;
            timeout_err_q  <= timeout_err_d;
            timeout_seen_q <= timeout_seen_d;
        end
    end
`endif

    assign req_ready     = req_ready_c;
    assign record_en     = record_en_q;
    assign sent_en       = sent_en_q;
    assign check_en      = check_en_q;
    assign invalid_en    = invalid_en_q;
    assign feat_rd_en    = feat_rd_en_q;
    assign target_row_id = target_row_id_q;
    assign target_col_id = target_col_id_q;
    assign hash_indices  = hash_indices_q;
    assign sent_in       = mask_q;
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign out_data      = out_valid_q ? feat_rd_data : '0;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_enc_lookup_ctrl.sv
// Testbench for enc_lookup_ctrl: the bench plays the lookup table and downstream sink,
// runs a table of batch scenarios and a few hand-written reset/timeout sequences.
module tb_enc_lookup_ctrl;

    localparam int DW  = 32;
    localparam int NB  = 8;
    localparam int BW  = DW * NB;
    localparam int COL = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_last = 1'b0;
    logic [BW-1:0] req_data = '0;
    logic [1:0]    record_en;
    logic          sent_en, check_en, invalid_en, feat_rd_en;
    logic [DW-1:0] target_row_id, target_col_id;
    logic [BW-1:0] hash_indices;
    logic [COL-1:0] sent_in;
    logic          full = 1'b0;
    logic          allocated = 1'b0;
    logic          all_returned = 1'b0;
    logic [DW-1:0] alloc_row_id = '0;
    logic [BW-1:0] feat_rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    enc_lookup_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last), .req_data(req_data),
        .record_en(record_en), .sent_en(sent_en), .check_en(check_en),
        .invalid_en(invalid_en), .feat_rd_en(feat_rd_en),
        .target_row_id(target_row_id), .target_col_id(target_col_id),
        .hash_indices(hash_indices), .sent_in(sent_in),
        .full(full), .allocated(allocated), .all_returned(all_returned),
        .alloc_row_id(alloc_row_id), .feat_rd_data(feat_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    typedef struct {
        int           last_at;    // beat index carrying req_last, -1 = never
        logic [31:0]  row;
        int           full_cyc;   // full held high for this many leading cycles
        int           gap_at;     // drop req_valid for 3 cycles before this beat, -1 = none
        int           rdy_gap;    // out_ready low cycles after first read
        bit           no_ret;     // never return all_returned
        int           rst_at;     // assert rst after this many 2'b11 records, 0 = none
        int           exp_rec11;
        logic [127:0] exp_mask;
        int           exp_beats;
        int           exp_chk;
        bit           exp_ovf;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [BW-1:0] beat_data(input int i);
        logic [BW-1:0] w;
        for (int k = 0; k < NB; k++) w[k*DW +: DW] = 32'hA000_0000 | (32'(i) << 8) | 32'(k);
        return w;
    endfunction

    function automatic logic [BW-1:0] feat_data(input logic [31:0] row, input int c);
        logic [BW-1:0] w;
        for (int k = 0; k < NB; k++) w[k*DW +: DW] = 32'hF000_0000 | (row << 16) | (32'(c) << 8) | 32'(k);
        return w;
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic outs_nonzero();
        return |{req_ready, record_en, sent_en, check_en, invalid_en, feat_rd_en,
                 target_row_id, target_col_id, hash_indices, sent_in,
                 out_valid, out_data, out_last, busy};
    endfunction

    task automatic run_batch(input vec_t v, input string tag);
        int bi = 0;
        bit req_done = 0;
        int gap_left = 0;
        bit gap_done = 0;
        int rdy_left = 0;
        bit rdy_armed = 0;
        bit prev_full = 0, prev_rd = 0, prev_ready = 1;
        int prev_col = 0;
        int rec01 = 0, rec11 = 0, rec_err = 0, full_err = 0, sent_cnt = 0;
        logic [31:0]  sent_row = '0, inv_row = '0;
        logic [127:0] sent_mask = '0;
        int chk_cnt = 0, rd_cnt = 0, rd_err = 0, rdy_err = 0, ov_err = 0;
        int out_beats = 0, data_err = 0, last_err = 0, multi = 0, cmds = 0;
        bit fin = 0, did_rst = 0, busy_seen = 0, busy_end = 1;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            @(negedge clk);
            full         = (cyc < v.full_cyc);
            allocated    = (record_en == 2'b01);
            alloc_row_id = allocated ? v.row : '0;
            all_returned = check_en && !v.no_ret;
            feat_rd_data = prev_rd ? feat_data(v.row, prev_col) : '0;
            out_ready    = (rdy_left == 0);
            if (rdy_left > 0) rdy_left--;
            if (!req_done && !gap_done && v.gap_at == bi) begin
                gap_left = 3;
                gap_done = 1;
            end
            if (req_done || gap_left > 0) begin
                req_valid = 1'b0;
                req_last  = 1'b0;
                if (gap_left > 0) gap_left--;
            end else begin
                req_valid = 1'b1;
                req_last  = (bi == v.last_at);
                req_data  = beat_data(bi);
            end
            #1;
            cmds = int'(record_en != 2'b00) + int'(sent_en) + int'(check_en) + int'(invalid_en) + int'(feat_rd_en);
            if (cmds > 1) multi++;
            if (busy) busy_seen = 1;
            if (record_en == 2'b01) begin
                rec01++;
                if (prev_full) full_err++;
                if (target_col_id != 0 || hash_indices != beat_data(0)) rec_err++;
            end else if (record_en == 2'b11) begin
                rec11++;
                if (target_row_id != v.row || target_col_id != rec11 || hash_indices != beat_data(rec11)) rec_err++;
            end else if (record_en != 2'b00) begin
                rec_err++;
            end
            if (sent_en) begin
                sent_cnt++;
                sent_row  = target_row_id;
                sent_mask = sent_in;
                req_done  = 1;
            end
            if (check_en) chk_cnt++;
            if (feat_rd_en) begin
                rd_cnt++;
                if (target_col_id != rd_cnt - 1) rd_err++;
                if (!prev_ready) rdy_err++;
                if (!rdy_armed) begin
                    rdy_armed = 1;
                    rdy_left  = v.rdy_gap;
                end
            end
            if (out_valid != prev_rd) ov_err++;
            if (out_valid) begin
                out_beats++;
                if (out_data != feat_data(v.row, out_beats - 1)) data_err++;
                if (out_last != (out_beats == v.exp_beats)) last_err++;
            end else if (out_last) begin
                last_err++;
            end
            if (invalid_en) begin
                inv_row  = target_row_id;
                busy_end = busy;
                fin      = 1;
            end
            if (req_valid && req_ready) begin
                if (req_last) req_done = 1;
                bi++;
            end
            prev_full  = full;
            prev_rd    = feat_rd_en;
            prev_col   = int'(target_col_id);
            prev_ready = out_ready;
            if (v.rst_at > 0 && rec11 == v.rst_at && !fin) begin
                req_valid = 1'b0;
                allocated = 1'b0;
                rst = 1'b1;
                #1;
                chk({tag, ".rst_async_zero"}, BW'(outs_nonzero()), '0);
                @(negedge clk);
                chk({tag, ".rst_held_zero"}, BW'(outs_nonzero()), '0);
                chk({tag, ".rst_row_col"}, BW'({dut.row_q, dut.col_q, dut.overflow_q}), '0);
                rst = 1'b0;
                did_rst = 1;
                fin = 1;
            end
        end
        req_valid = 1'b0;
        req_last  = 1'b0;
        chk({tag, ".finished"}, BW'(fin), BW'(1));
        if (!did_rst) begin
            chk({tag, ".rec01_count"},  BW'(rec01), BW'(1));
            chk({tag, ".rec11_count"},  BW'(rec11), BW'(v.exp_rec11));
            chk({tag, ".rec_fields"},   BW'(rec_err), '0);
            chk({tag, ".rec_in_full"},  BW'(full_err), '0);
            chk({tag, ".sent_count"},   BW'(sent_cnt), BW'(1));
            chk({tag, ".sent_row"},     BW'(sent_row), BW'(v.row));
            chk({tag, ".sent_mask"},    BW'(sent_mask), BW'(v.exp_mask));
            chk({tag, ".check_count"},  BW'(chk_cnt), BW'(v.exp_chk));
            chk({tag, ".read_count"},   BW'(rd_cnt), BW'(v.exp_beats));
            chk({tag, ".read_cols"},    BW'(rd_err), '0);
            chk({tag, ".read_no_rdy"},  BW'(rdy_err), '0);
            chk({tag, ".out_latency"},  BW'(ov_err), '0);
            chk({tag, ".out_beats"},    BW'(out_beats), BW'(v.exp_beats));
            chk({tag, ".out_data"},     BW'(data_err), '0);
            chk({tag, ".out_last"},     BW'(last_err), '0);
            chk({tag, ".one_cmd"},      BW'(multi), '0);
            chk({tag, ".inv_row"},      BW'(inv_row), BW'(v.row));
            chk({tag, ".busy"},         BW'({busy_seen, busy_end}), BW'(2'b10));
            chk({tag, ".overflow"},     BW'(dut.overflow_q), BW'(v.exp_ovf));
        end
    endtask

    initial begin
        vecs[0] = '{last_at:0,  row:5,  full_cyc:0,  gap_at:-1, rdy_gap:0, no_ret:0, rst_at:0,
                    exp_rec11:0,  exp_mask:128'hFF,        exp_beats:1,  exp_chk:2, exp_ovf:0};
        vecs[1] = '{last_at:2,  row:9,  full_cyc:0,  gap_at:-1, rdy_gap:0, no_ret:0, rst_at:0,
                    exp_rec11:2,  exp_mask:128'hFF_FFFF,   exp_beats:3,  exp_chk:2, exp_ovf:0};
        vecs[2] = '{last_at:1,  row:3,  full_cyc:10, gap_at:-1, rdy_gap:0, no_ret:0, rst_at:0,
                    exp_rec11:1,  exp_mask:128'hFFFF,      exp_beats:2,  exp_chk:2, exp_ovf:0};
        vecs[3] = '{last_at:3,  row:7,  full_cyc:0,  gap_at:2,  rdy_gap:4, no_ret:0, rst_at:0,
                    exp_rec11:3,  exp_mask:128'hFFFF_FFFF, exp_beats:4,  exp_chk:2, exp_ovf:0};
        vecs[4] = '{last_at:-1, row:31, full_cyc:0,  gap_at:-1, rdy_gap:0, no_ret:0, rst_at:0,
                    exp_rec11:15, exp_mask:{128{1'b1}},    exp_beats:16, exp_chk:2, exp_ovf:1};

        #2 rst = 1'b1;
        #1 chk("reset_outputs_zero", BW'(outs_nonzero()), '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_batch(vecs[i], $sformatf("vec%0d", i));

        // Reset lands while the block is in RECORD; a clean batch must follow.
        run_batch('{last_at:5, row:12, full_cyc:0, gap_at:-1, rdy_gap:0, no_ret:0, rst_at:2,
                    exp_rec11:5, exp_mask:128'hFFFF_FFFF_FFFF, exp_beats:6, exp_chk:2, exp_ovf:0}, "mid_rst");
        run_batch(vecs[0], "after_rst");

`ifdef ENC_LOOKUP_CTRL_TIMEOUT_EN
        run_batch('{last_at:0, row:6, full_cyc:0, gap_at:-1, rdy_gap:0, no_ret:1, rst_at:0,
                    exp_rec11:0, exp_mask:128'hFF, exp_beats:0, exp_chk:16, exp_ovf:0}, "timeout");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
